cpu_ex_hilo: RTL



---
 rtl/cpu_ex_hilo_if.sv | 47 ++++
 rtl/cpu_ex_hilo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cpu_ex_hilo_if.sv
// Shared types and the ID/EX-to-HI/LO execute interface.
// The package sits ahead of the interface so that both the interface and the module can import it.
package cpu_ex_hilo_pkg;
    typedef enum logic [3:0] {
        OP_INVALID,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO,
        OP_MFHI,
        OP_MFLO,
        OP_ADD
    } Oper_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } RegWriteReq_t;
endpackage

interface cpu_ex_hilo_if;
    import cpu_ex_hilo_pkg::*;

    Oper_t        op;
    logic [31:0]  reg1;
    logic [31:0]  reg2;
    logic         reg_we;
    logic [4:0]   reg_waddr;
    logic         flush;
    logic         stall_req;
    RegWriteReq_t wr;
    logic [31:0]  hi;
    logic [31:0]  lo;

    modport master (
        output op, reg1, reg2, reg_we, reg_waddr, flush,
        input  stall_req, wr, hi, lo
    );

    modport slave (
        input  op, reg1, reg2, reg_we, reg_waddr, flush,
        output stall_req, wr, hi, lo
    );
endinterface

// File: rtl/cpu_ex_hilo.sv
// HI/LO execute unit: single-cycle MULT/MULTU/MTHI/MTLO/MFHI/MFLO and an iterative
// restoring divider that stalls the pipeline while a DIV/DIVU is in flight.
module cpu_ex_hilo
    import cpu_ex_hilo_pkg::*;
#(
    parameter int unsigned DIV_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_ex_hilo_if.slave  ex
);
    localparam int unsigned DIV_ITERS = 32 / DIV_STEP;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [4:0]   cnt, cnt_nxt;
    logic [31:0]  hi_q, hi_nxt;
    logic [31:0]  lo_q, lo_nxt;
    logic [32:0]  rem_q, rem_nxt;
    logic [31:0]  quo_q, quo_nxt;
    logic [31:0]  dvs_q, dvs_nxt;
    logic         q_neg_q, q_neg_nxt;
    logic         r_neg_q, r_neg_nxt;

    logic         is_div;
    logic         s1, s2;
    logic [31:0]  abs1, abs2;
    logic [63:0]  prod_s, prod_u;
    logic [32:0]  rem_w;
    logic [31:0]  quo_w;
    logic [31:0]  quo_res, rem_res;
    logic         stall_c;
    RegWriteReq_t wr_c;

    always_comb begin
        is_div = (ex.op == OP_DIV) || (ex.op == OP_DIVU);
        s1     = (ex.op == OP_DIV) && ex.reg1[31];
        s2     = (ex.op == OP_DIV) && ex.reg2[31];
        abs1   = s1 ? (~ex.reg1 + 32'd1) : ex.reg1;
        abs2   = s2 ? (~ex.reg2 + 32'd1) : ex.reg2;
        prod_s = $signed({{32{ex.reg1[31]}}, ex.reg1}) * $signed({{32{ex.reg2[31]}}, ex.reg2});
        prod_u = {32'd0, ex.reg1} * {32'd0, ex.reg2};
        quo_res = q_neg_q ? (~quo_q + 32'd1) : quo_q;
        rem_res = r_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    end

    // Quotient bits shift into the low end of the dividend register as it empties.
    always_comb begin
        rem_w = rem_q;
        quo_w = quo_q;
        for (int unsigned i = 0; i < DIV_STEP; i++) begin
            rem_w = {rem_w[31:0], quo_w[31]};
            quo_w = {quo_w[30:0], 1'b0};
            if (rem_w >= {1'b0, dvs_q}) begin
                rem_w    = rem_w - {1'b0, dvs_q};
                quo_w[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        rem_nxt   = rem_q;
        quo_nxt   = quo_q;
        dvs_nxt   = dvs_q;
        q_neg_nxt = q_neg_q;
        r_neg_nxt = r_neg_q;
        stall_c   = 1'b0;
        wr_c      = '0;

        if (ex.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        stall_c = 1'b1;
                        cnt_nxt = '0;
                        if (ex.reg2 == '0) begin
                            // Divide-by-zero reuses the DONE path with a preset result.
                            rem_nxt   = {1'b0, ex.reg1};
                            quo_nxt   = '1;
                            q_neg_nxt = 1'b0;
                            r_neg_nxt = 1'b0;
                            state_nxt = DONE;
                        end else begin
                            rem_nxt   = '0;
                            quo_nxt   = abs1;
                            dvs_nxt   = abs2;
                            q_neg_nxt = s1 ^ s2;
                            r_neg_nxt = s1;
                            state_nxt = BUSY;
                        end
                    end else begin
                        case (ex.op)
                            OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
                            OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
                            OP_MTHI:  hi_nxt = ex.reg1;
                            OP_MTLO:  lo_nxt = ex.reg1;
                            OP_MFHI: begin
                                wr_c.we    = ex.reg_we;
                                wr_c.waddr = ex.reg_waddr;
                                wr_c.wdata = hi_q;
                            end
                            OP_MFLO: begin
                                wr_c.we    = ex.reg_we;
                                wr_c.waddr = ex.reg_waddr;
                                wr_c.wdata = lo_q;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    stall_c = 1'b1;
                    rem_nxt = rem_w;
                    quo_nxt = quo_w;
                    cnt_nxt = cnt + 5'd1;
                    if (cnt == 5'(DIV_ITERS - 1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    hi_nxt    = rem_res;
                    lo_nxt    = quo_res;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            rem_q   <= rem_nxt;
            quo_q   <= quo_nxt;
            dvs_q   <= dvs_nxt;
            q_neg_q <= q_neg_nxt;
            r_neg_q <= r_neg_nxt;
        end
    end

    assign ex.stall_req = stall_c;
    assign ex.wr        = wr_c;
    assign ex.hi        = hi_q;
    assign ex.lo        = lo_q;
endmodule
